readout_merge_arb: RTL
======================

# readout_merge_arb

Merges the two priority-readout hit streams (upper and lower matrix halves) into one tagged hit stream for the downstream serializer. Each half gets a small FIFO, because the priority encoders have no back-pressure. A round-robin arbiter drains both FIFOs into a single valid/ready output register. Hits that arrive while a FIFO is full are dropped and counted per half.

## Interface
Parameters:
- ADDR_W, 15: pixel address width
- FIFO_DEPTH, 4: entries per half; power of two, at least 2
- CNT_W, 16: width of the drop counters

Ports:
- sys_clock  in  1  system clock; all logic on rising edge
- sys_reset  in  1  asynchronous, active-high reset
- up_valid_i  in  1  upper-half hit strobe, one hit per cycle
- up_addr_i  in  ADDR_W  upper-half hit address
- down_valid_i  in  1  lower-half hit strobe
- down_addr_i  in  ADDR_W  lower-half hit address
- hit_valid_o  out  1  merged hit available
- hit_ready_i  in  1  downstream accepts the hit
- hit_data_o  out  ADDR_W+1  {half, addr}; half 0 = up, 1 = down
- up_drop_cnt_o  out  CNT_W  saturating count of dropped up hits
- down_drop_cnt_o  out  CNT_W  saturating count of dropped down hits
- clr_cnt_i  in  1  synchronous clear of both drop counters

## Operation
- Push:
  - A valid strobe sampled at an edge writes the address into that half's FIFO if the FIFO is not full.
  - If the FIFO is full and no pop occurs that cycle, the hit is dropped and the half's drop counter increments.
  - Push into a full FIFO while that FIFO pops in the same cycle is accepted, with no drop.
- Output register:
  - It is "free" when hit_valid_o=0, or when hit_valid_o=1 and hit_ready_i=1.
  - When it is free and at least one FIFO is non-empty, it loads one FIFO head, pops that FIFO, and sets hit_valid_o=1.
  - When it is free and both FIFOs are empty, hit_valid_o goes to 0.
- Arbitration:
  - If only one FIFO is non-empty, that FIFO is granted.
  - If both are non-empty, the half not granted last time wins.
  - last_grant updates only on an actual load.
- Handshake:
  - Once hit_valid_o=1, hit_data_o is held stable until hit_ready_i=1.
  - hit_valid_o never drops without acceptance, except on reset.
- Drop counters:
  - Saturate at all-ones.
  - clr_cnt_i has priority: a drop coincident with clear is not counted, and the counter reads 0 next cycle.
- Reset, asynchronous at any time:
  - Both FIFOs are flushed.
  - hit_valid_o=0, hit_data_o=0, both counters=0.
  - last_grant=down, so the first contested grant goes to up.
  - Hits presented in the reset cycle are discarded.

## Timing
- Latency: a hit sampled at edge E0 into an empty system appears on hit_valid_o/hit_data_o after edge E1 (2-cycle latency). There is no combinational path from inputs to outputs.
- Throughput: one hit per cycle on the output with hit_ready_i held at 1. Combined input rate of 2 per cycle therefore builds FIFO occupancy.
- FIFO full/empty: pointers are ADDR bits plus one wrap bit. Full means pointers are equal and the wrap bits differ; wrap-around at FIFO_DEPTH is transparent.
- Counters update the edge after the drop event.
- Everything is registered; outputs come directly from flops.

## Structure
- Package readout_pkg:
  - localparam ADDR_W=15
  - typedef enum logic {HALF_UP=1'b0, HALF_DOWN=1'b1} half_e
  - typedef struct packed {half_e half; logic [ADDR_W-1:0] addr;} hit_t
- Sub-module hit_fifo (synchronous FIFO with push, pop, full, empty and head data; parameterised width and depth), instantiated twice.
- The top level contains the arbiter, the output register and the drop counters.

## Test plan
- Single hit: up_valid_i=1 with addr 0x1234 for one cycle, hit_ready_i=1 → hit_data_o=0x1234 (half 0) two edges later, valid for exactly one cycle.
- Contention: up and down hit every cycle for 4 cycles (up 0x10–0x13, down 0x20–0x23), ready=1 → output order up0x10, dn0x20, up0x11, dn0x21, …; 8 hits total, no drops.
- Back-pressure:
  - Step 1: hit_ready_i=0 while 6 up hits arrive (DEPTH=4) → output holds the first hit stable; 4 hits in the FIFO; up_drop_cnt_o=1.
  - Step 2: release ready → remaining 5 hits delivered in order.
- Full with simultaneous pop: FIFO full and ready=1 while a new up hit arrives → hit accepted, drop count unchanged.
- Counter behaviour:
  - Force CNT_W=2: 5 drops → counter saturates at 3.
  - clr_cnt_i coincident with a drop → counter reads 0.
- Mid-operation reset: assert sys_reset asynchronously with both FIFOs partially full and hit_valid_o=1 → all outputs 0 immediately. After release, the first contested grant goes to up.

Source files
------------

// File: rtl/readout_merge_arb_pkg.sv
// Shared types for the readout merge path: half identifier and tagged hit layout.
package readout_pkg;

  localparam int ADDR_W = 15;

  typedef enum logic {
    HALF_UP   = 1'b0,
    HALF_DOWN = 1'b1
  } half_e;

  typedef struct packed {
    half_e             half;
    logic [ADDR_W-1:0] addr;
  } hit_t;

endpackage

// File: rtl/readout_merge_arb_if.sv
// Hit input, merged output and drop-counter bundle between the merge block and its neighbours.
interface readout_merge_arb_if #(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
) ();

  logic              up_valid_i;
  logic [ADDR_W-1:0] up_addr_i;
  logic              down_valid_i;
  logic [ADDR_W-1:0] down_addr_i;
  logic              hit_valid_o;
  logic              hit_ready_i;
  logic [ADDR_W:0]   hit_data_o;
  logic [CNT_W-1:0]  up_drop_cnt_o;
  logic [CNT_W-1:0]  down_drop_cnt_o;
  logic              clr_cnt_i;

  modport slave (
    input  up_valid_i, up_addr_i, down_valid_i, down_addr_i, hit_ready_i, clr_cnt_i,
    output hit_valid_o, hit_data_o, up_drop_cnt_o, down_drop_cnt_o
  );

  modport master (
    output up_valid_i, up_addr_i, down_valid_i, down_addr_i, hit_ready_i, clr_cnt_i,
    input  hit_valid_o, hit_data_o, up_drop_cnt_o, down_drop_cnt_o
  );

endinterface

// File: rtl/readout_merge_arb_hit_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module hit_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/readout_merge_arb.sv
// Merges upper/lower priority-readout hit streams through per-half FIFOs and a
// round-robin arbiter into one registered valid/ready stream; counts dropped hits.
module readout_merge_arb #(
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               sys_clock,
  input  logic               sys_reset,
  readout_merge_arb_if.slave bus
);

  import readout_pkg::half_e;
  import readout_pkg::HALF_UP;
  import readout_pkg::HALF_DOWN;

  logic              w_up_full;
  logic              w_up_empty;
  logic [ADDR_W-1:0] w_up_head;
  logic              w_dn_full;
  logic              w_dn_empty;
  logic [ADDR_W-1:0] w_dn_head;

  logic              w_free;
  logic              w_load;
  half_e             w_sel;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_pop_up;
  logic              w_pop_dn;
  logic              w_up_drop;
  logic              w_dn_drop;

  logic              r_hit_valid;
  logic [ADDR_W:0]   r_hit_data;
  half_e             r_last_grant;
  logic [CNT_W-1:0]  r_up_drop_cnt;
  logic [CNT_W-1:0]  r_dn_drop_cnt;

  hit_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo_up (
    .clk     (sys_clock),
    .rst     (sys_reset),
    .i_push  (bus.up_valid_i),
    .i_pop   (w_pop_up),
    .i_data  (bus.up_addr_i),
    .o_full  (w_up_full),
    .o_empty (w_up_empty),
    .o_head  (w_up_head)
  );

  hit_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo_dn (
    .clk     (sys_clock),
    .rst     (sys_reset),
    .i_push  (bus.down_valid_i),
    .i_pop   (w_pop_dn),
    .i_data  (bus.down_addr_i),
    .o_full  (w_dn_full),
    .o_empty (w_dn_empty),
    .o_head  (w_dn_head)
  );

  assign w_free = !r_hit_valid || bus.hit_ready_i;
  assign w_load = w_free && (!w_up_empty || !w_dn_empty);

  // Round robin only matters when both halves have data.
  always_comb begin
    w_sel = HALF_UP;
    if (!w_up_empty && !w_dn_empty) begin
      w_sel = (r_last_grant == HALF_DOWN) ? HALF_UP : HALF_DOWN;
    end else if (w_up_empty) begin
      w_sel = HALF_DOWN;
    end
  end

  assign w_sel_addr = (w_sel == HALF_UP) ? w_up_head : w_dn_head;
  assign w_pop_up   = w_load && (w_sel == HALF_UP);
  assign w_pop_dn   = w_load && (w_sel == HALF_DOWN);
  assign w_up_drop  = bus.up_valid_i && w_up_full && !w_pop_up;
  assign w_dn_drop  = bus.down_valid_i && w_dn_full && !w_pop_dn;

  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      r_hit_valid  <= 1'b0;
      r_hit_data   <= '0;
      r_last_grant <= HALF_DOWN;
    end else if (w_free) begin
      if (w_load) begin
        r_hit_valid  <= 1'b1;
        r_hit_data   <= {w_sel, w_sel_addr};
        r_last_grant <= w_sel;
      end else begin
        r_hit_valid  <= 1'b0;
      end
    end
  end

  // Clear wins over a coincident drop; counters stick at all-ones.
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      r_up_drop_cnt <= '0;
      r_dn_drop_cnt <= '0;
    end else if (bus.clr_cnt_i) begin
      r_up_drop_cnt <= '0;
      r_dn_drop_cnt <= '0;
    end else begin
      if (w_up_drop && (r_up_drop_cnt != '1)) r_up_drop_cnt <= r_up_drop_cnt + 1'b1;
      if (w_dn_drop && (r_dn_drop_cnt != '1)) r_dn_drop_cnt <= r_dn_drop_cnt + 1'b1;
    end
  end

  assign bus.hit_valid_o     = r_hit_valid;
  assign bus.hit_data_o      = r_hit_data;
  assign bus.up_drop_cnt_o   = r_up_drop_cnt;
  assign bus.down_drop_cnt_o = r_dn_drop_cnt;

endmodule
